// File: rtl/id_stage_if.sv
// Bundle of every signal crossing the decode stage boundary except clock and reset.
// slave is the decode stage itself; master is whatever drives it (fetch/EX/WB or a bench).
interface id_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            stall_c_i;
  logic            flush_c_i;
  logic [31:0]     instruction_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] pc_next_i;
  // writeback and EX feedback
  logic            wb_wen_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            ex_mem_read_i;
  logic [4:0]      ex_rd_i;
  // decoded instruction towards EX
  logic            load_use_stall_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_next_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic [31:0]     imm_o;
  logic [2:0]      funct3_o;
  logic [3:0]      alu_op_o;
  logic            alu_src_a_o;
  logic            alu_src_b_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            reg_write_o;
  logic            branch_o;
  logic            jump_o;
  logic            jalr_o;
  logic [1:0]      wb_sel_o;
  logic            illegal_o;

  modport master (
    output stall_c_i, flush_c_i, instruction_i, pc_i, pc_next_i,
           wb_wen_i, wb_rd_i, wb_data_i, ex_mem_read_i, ex_rd_i,
    input  load_use_stall_o, pc_o, pc_next_o, rs1_o, rs2_o, rd_o,
           rs1_data_o, rs2_data_o, imm_o, funct3_o, alu_op_o, alu_src_a_o,
           alu_src_b_o, mem_read_o, mem_write_o, reg_write_o, branch_o,
           jump_o, jalr_o, wb_sel_o, illegal_o
  );

  modport slave (
    input  stall_c_i, flush_c_i, instruction_i, pc_i, pc_next_i,
           wb_wen_i, wb_rd_i, wb_data_i, ex_mem_read_i, ex_rd_i,
    output load_use_stall_o, pc_o, pc_next_o, rs1_o, rs2_o, rd_o,
           rs1_data_o, rs2_data_o, imm_o, funct3_o, alu_op_o, alu_src_a_o,
           alu_src_b_o, mem_read_o, mem_write_o, reg_write_o, branch_o,
           jump_o, jalr_o, wb_sel_o, illegal_o
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, 32-entry register file with write-through
// bypass, combinational decode and load-use hazard detection.
//
// Flow control: there is no valid/ready pair here. The IF/ID register loads
// every cycle unless held; it is held when stall_c_i or load_use_stall_o is
// high, and flush_c_i overrides a hold by loading a bubble. While the stage
// emits a bubble (empty slot, load-use hazard or illegal opcode) all
// side-effecting controls are 0, so EX can consume every cycle unconditionally.
module id_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic   clk,
  input logic   rst_n,
  id_stage_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next_q;
  logic            valid_q;
  logic [XLEN-1:0] regs [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm;
  logic [3:0]  alu;
  logic        src_a, src_b, mr, mw, rw, br, jmp, jr, known, uses_rs1, uses_rs2;
  logic [1:0]  wbs;
  logic        load_use, illegal, bubble;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign rd     = instr_q[11:7];

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  // funct3 to ALU op; alt picks SUB/SRA where the encoding allows it
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  // IF/ID register: flush beats hold, hold beats load
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_c_i) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else if (!(bus.stall_c_i || load_use)) begin
      instr_q   <= bus.instruction_i;
      pc_q      <= bus.pc_i;
      pc_next_q <= bus.pc_next_i;
      valid_q   <= 1'b1;
    end
  end

  // register file write port; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_wen_i && bus.wb_rd_i != 5'd0) begin
      regs[bus.wb_rd_i] <= bus.wb_data_i;
    end
  end

  // operand reads with same-cycle writeback bypass
  always_comb begin
    bus.rs1_data_o = '0;
    bus.rs2_data_o = '0;
    if (rs1 != 5'd0)
      bus.rs1_data_o = (bus.wb_wen_i && bus.wb_rd_i == rs1) ? bus.wb_data_i : regs[rs1];
    if (rs2 != 5'd0)
      bus.rs2_data_o = (bus.wb_wen_i && bus.wb_rd_i == rs2) ? bus.wb_data_i : regs[rs2];
  end

  // raw opcode decode, before bubble masking
  always_comb begin
    imm      = imm_i;
    alu      = ALU_ADD;
    src_a    = 1'b0;
    src_b    = 1'b0;
    mr       = 1'b0;
    mw       = 1'b0;
    rw       = 1'b0;
    br       = 1'b0;
    jmp      = 1'b0;
    jr       = 1'b0;
    wbs      = 2'd0;
    known    = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI:    begin alu = ALU_PASSB; imm = imm_u; src_b = 1'b1; rw = 1'b1; uses_rs1 = 1'b0; end
      OPC_AUIPC:  begin imm = imm_u; src_a = 1'b1; src_b = 1'b1; rw = 1'b1; uses_rs1 = 1'b0; end
      OPC_JAL:    begin imm = imm_j; src_a = 1'b1; src_b = 1'b1; rw = 1'b1; jmp = 1'b1;
                        wbs = 2'd2; uses_rs1 = 1'b0; end
      OPC_JALR:   begin src_b = 1'b1; rw = 1'b1; jr = 1'b1; wbs = 2'd2; end
      OPC_BRANCH: begin imm = imm_b; alu = ALU_SUB; br = 1'b1; uses_rs2 = 1'b1; end
      OPC_LOAD:   begin src_b = 1'b1; rw = 1'b1; mr = 1'b1; wbs = 2'd1; end
      OPC_STORE:  begin imm = imm_s; src_b = 1'b1; mw = 1'b1; uses_rs2 = 1'b1; end
      OPC_OP_IMM: begin src_b = 1'b1; rw = 1'b1;
                        alu = f3_op(funct3, instr_q[30] && funct3 == 3'b101); end
      OPC_OP:     begin rw = 1'b1; uses_rs2 = 1'b1; alu = f3_op(funct3, instr_q[30]); end
      OPC_FENCE, OPC_SYSTEM: begin end
      default:    known = 1'b0;
    endcase
  end

  assign load_use = valid_q && bus.ex_mem_read_i && bus.ex_rd_i != 5'd0 &&
                    ((uses_rs1 && bus.ex_rd_i == rs1) || (uses_rs2 && bus.ex_rd_i == rs2));
  assign illegal  = valid_q && !known;
  assign bubble   = !valid_q || load_use || illegal;

  // output drive with bubble masking
  always_comb begin
    bus.load_use_stall_o = load_use;
    bus.illegal_o        = illegal;
    bus.pc_o             = pc_q;
    bus.pc_next_o        = pc_next_q;
    bus.rs1_o            = rs1;
    bus.rs2_o            = rs2;
    bus.rd_o             = rd;
    bus.funct3_o         = funct3;
    bus.imm_o            = imm;
    bus.alu_op_o         = bubble ? ALU_ADD : alu;
    bus.alu_src_a_o      = !bubble && src_a;
    bus.alu_src_b_o      = !bubble && src_b;
    bus.wb_sel_o         = bubble ? 2'd0 : wbs;
    bus.mem_read_o       = !bubble && mr;
    bus.mem_write_o      = !bubble && mw;
    bus.reg_write_o      = !bubble && rw && rd != 5'd0;
    bus.branch_o         = !bubble && br;
    bus.jump_o           = !bubble && jmp;
    bus.jalr_o           = !bubble && jr;
  end
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by randomized instruction
// streams, all checked against an instruction-level model of the decode stage.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) bus ();
  id_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP,
                K_FENCE, K_SYS, K_BAD} kind_t;

  // model state: IF/ID slot and architectural registers
  logic [31:0] m_instr;
  logic [31:0] m_pc, m_pcn;
  logic        m_valid;
  logic [31:0] m_regs [32];

  function automatic kind_t kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h37:   return K_LUI;
      7'h17:   return K_AUIPC;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      7'h63:   return K_BR;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h13:   return K_OPI;
      7'h33:   return K_OP;
      7'h0F:   return K_FENCE;
      7'h73:   return K_SYS;
      default: return K_BAD;
    endcase
  endfunction

  // immediate as a signed value: sum of weighted fields minus the sign weight
  function automatic int imm_of(input kind_t k, input logic [31:0] ins);
    int sgn;
    sgn = ins[31] ? 1 : 0;
    case (k)
      K_LUI, K_AUIPC: return int'(ins & 32'hFFFF_F000);
      K_JAL: return int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - sgn * 1048576;
      K_BR:  return int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - sgn * 4096;
      K_ST:  return int'(ins[30:25]) * 32 + int'(ins[11:7]) - sgn * 2048;
      default: return int'(ins[30:20]) - sgn * 2048;
    endcase
  endfunction

  function automatic int alu_of(input kind_t k, input logic [31:0] ins);
    int tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int f3;
    f3 = int'(ins[14:12]);
    case (k)
      K_LUI: return 10;
      K_BR:  return 1;
      K_OPI: return (f3 == 5 && ins[30]) ? 7 : tab[f3];
      K_OP:  begin
        if (ins[30] && f3 == 0) return 1;
        if (ins[30] && f3 == 5) return 7;
        return tab[f3];
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_wen_i && bus.wb_rd_i == idx) return bus.wb_data_i;
    return m_regs[idx];
  endfunction

  function automatic logic model_lu();
    kind_t k;
    logic  u1, u2;
    k  = kind_of(m_instr);
    u1 = !(k == K_LUI || k == K_AUIPC || k == K_JAL);
    u2 = (k == K_BR || k == K_ST || k == K_OP);
    return m_valid && bus.ex_mem_read_i && bus.ex_rd_i != 5'd0 &&
           ((u1 && bus.ex_rd_i == m_instr[19:15]) || (u2 && bus.ex_rd_i == m_instr[24:20]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // compare every output against the model at the falling edge
  task automatic sample(input string tag);
    kind_t k;
    logic  lu, ill, bub, live;
    @(negedge clk);
    k    = kind_of(m_instr);
    lu   = model_lu();
    ill  = m_valid && k == K_BAD;
    bub  = !m_valid || lu || ill;
    live = !bub;
    chk({tag, ".load_use"}, 32'(bus.load_use_stall_o), 32'(lu));
    chk({tag, ".illegal"},  32'(bus.illegal_o), 32'(ill));
    chk({tag, ".pc"},       bus.pc_o, m_pc);
    chk({tag, ".pc_next"},  bus.pc_next_o, m_pcn);
    chk({tag, ".rs1"},      32'(bus.rs1_o), 32'(m_instr[19:15]));
    chk({tag, ".rs2"},      32'(bus.rs2_o), 32'(m_instr[24:20]));
    chk({tag, ".rd"},       32'(bus.rd_o), 32'(m_instr[11:7]));
    chk({tag, ".funct3"},   32'(bus.funct3_o), 32'(m_instr[14:12]));
    chk({tag, ".rs1_data"}, bus.rs1_data_o, rd_reg(m_instr[19:15]));
    chk({tag, ".rs2_data"}, bus.rs2_data_o, rd_reg(m_instr[24:20]));
    chk({tag, ".alu_op"},   32'(bus.alu_op_o), live ? 32'(alu_of(k, m_instr)) : 32'd0);
    chk({tag, ".mem_read"}, 32'(bus.mem_read_o), 32'(live && k == K_LD));
    chk({tag, ".mem_write"}, 32'(bus.mem_write_o), 32'(live && k == K_ST));
    chk({tag, ".reg_write"}, 32'(bus.reg_write_o),
        32'(live && m_instr[11:7] != 5'd0 &&
            (k == K_LUI || k == K_AUIPC || k == K_JAL || k == K_JALR ||
             k == K_LD || k == K_OPI || k == K_OP)));
    chk({tag, ".branch"},   32'(bus.branch_o), 32'(live && k == K_BR));
    chk({tag, ".jump"},     32'(bus.jump_o), 32'(live && k == K_JAL));
    chk({tag, ".jalr"},     32'(bus.jalr_o), 32'(live && k == K_JALR));
    if (k != K_OP && k != K_FENCE && k != K_SYS && k != K_BAD)
      chk({tag, ".imm"}, bus.imm_o, 32'(imm_of(k, m_instr)));
    if (live && k != K_FENCE && k != K_SYS) begin
      chk({tag, ".src_a"}, 32'(bus.alu_src_a_o), 32'(k == K_AUIPC || k == K_JAL));
      chk({tag, ".wb_sel"}, 32'(bus.wb_sel_o),
          (k == K_LD) ? 32'd1 : (k == K_JAL || k == K_JALR) ? 32'd2 : 32'd0);
      if (k != K_JAL && k != K_JALR)
        chk({tag, ".src_b"}, 32'(bus.alu_src_b_o), 32'(k != K_BR && k != K_OP));
    end
  endtask

  // clock edge: advance the model exactly as the stage should
  task automatic tick();
    logic lu;
    @(posedge clk);
    lu = model_lu();
    if (!rst_n) begin
      m_instr = 32'h13; m_pc = 0; m_pcn = 0; m_valid = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else begin
      if (bus.wb_wen_i && bus.wb_rd_i != 5'd0) m_regs[bus.wb_rd_i] = bus.wb_data_i;
      if (bus.flush_c_i) begin
        m_instr = 32'h13; m_pc = 0; m_pcn = 0; m_valid = 0;
      end else if (!(bus.stall_c_i || lu)) begin
        m_instr = bus.instruction_i; m_pc = bus.pc_i; m_pcn = bus.pc_next_i; m_valid = 1;
      end
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
    bus.instruction_i = ins;
    bus.pc_i          = pc;
    bus.pc_next_i     = pc + 32'd4;
  endtask

  initial begin
    logic [6:0] opc_pool [12];
    opc_pool = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    bus.stall_c_i = 0; bus.flush_c_i = 0; bus.wb_wen_i = 0; bus.wb_rd_i = 0;
    bus.wb_data_i = 0; bus.ex_mem_read_i = 0; bus.ex_rd_i = 0;
    fetch(32'h13, 32'h0);
    m_instr = 32'h13; m_pc = 0; m_pcn = 0; m_valid = 0;
    tick(); tick();

    // reset state, idle cycle
    rst_n = 1;
    sample("reset");
    chk("reset.pc_o", bus.pc_o, 32'h0);
    chk("reset.reg_write", 32'(bus.reg_write_o), 32'd0);
    chk("reset.load_use", 32'(bus.load_use_stall_o), 32'd0);
    chk("reset.jump", 32'(bus.jump_o), 32'd0);
    tick();

    // addi x1,x0,5 at pc 0x10
    fetch(32'h0050_0093, 32'h10);
    sample("idle");
    tick();
    fetch(32'h0010_8133, 32'h14);                 // add x2,x1,x1
    sample("addi");
    chk("addi.rd", 32'(bus.rd_o), 32'd1);
    chk("addi.imm", bus.imm_o, 32'd5);
    chk("addi.src_b", 32'(bus.alu_src_b_o), 32'd1);
    chk("addi.reg_write", 32'(bus.reg_write_o), 32'd1);
    chk("addi.pc_o", bus.pc_o, 32'h10);
    tick();

    // writeback bypass while decoding add x2,x1,x1
    bus.wb_wen_i = 1; bus.wb_rd_i = 1; bus.wb_data_i = 32'hDEAD_BEEF;
    fetch(32'h0000_8133, 32'h18);                 // add x2,x1,x0
    sample("bypass");
    chk("bypass.rs1_data", bus.rs1_data_o, 32'hDEAD_BEEF);
    chk("bypass.rs2_data", bus.rs2_data_o, 32'hDEAD_BEEF);
    tick();

    // load-use hazard on x1; concurrent wb to x0 must be ignored
    bus.wb_rd_i = 0; bus.wb_data_i = 32'h1234_5678;
    bus.ex_mem_read_i = 1; bus.ex_rd_i = 1;
    fetch(32'h0000_0063, 32'h1C);                 // beq x0,x0,0
    sample("lu");
    chk("lu.stall", 32'(bus.load_use_stall_o), 32'd1);
    chk("lu.reg_write", 32'(bus.reg_write_o), 32'd0);
    chk("lu.x0_reads_0", bus.rs2_data_o, 32'd0);
    chk("lu.x1_written", bus.rs1_data_o, 32'hDEAD_BEEF);
    tick();
    bus.wb_wen_i = 0; bus.ex_rd_i = 0;
    sample("lu_clear");
    chk("lu_clear.held_pc", bus.pc_o, 32'h18);
    chk("lu_clear.stall", 32'(bus.load_use_stall_o), 32'd0);
    chk("lu_clear.reg_write", 32'(bus.reg_write_o), 32'd1);
    tick();

    // flush and stall together with beq in IF/ID
    bus.ex_mem_read_i = 0;
    bus.flush_c_i = 1; bus.stall_c_i = 1;
    sample("beq");
    chk("beq.branch", 32'(bus.branch_o), 32'd1);
    tick();
    bus.flush_c_i = 0; bus.stall_c_i = 0;
    fetch(32'hFF9F_F0EF, 32'h40);                 // jal x1,-8
    sample("flushed");
    chk("flushed.branch", 32'(bus.branch_o), 32'd0);
    chk("flushed.pc_o", bus.pc_o, 32'h0);
    chk("flushed.illegal", 32'(bus.illegal_o), 32'd0);
    tick();
    fetch(32'h0000_007F, 32'h44);
    sample("jal");
    chk("jal.imm", bus.imm_o, 32'hFFFF_FFF8);
    chk("jal.jump", 32'(bus.jump_o), 32'd1);
    chk("jal.wb_sel", 32'(bus.wb_sel_o), 32'd2);
    tick();
    fetch(32'h13, 32'h48);
    sample("illegal");
    chk("illegal.flag", 32'(bus.illegal_o), 32'd1);
    chk("illegal.reg_write", 32'(bus.reg_write_o), 32'd0);
    chk("illegal.mem_read", 32'(bus.mem_read_o), 32'd0);
    chk("illegal.alu_op", 32'(bus.alu_op_o), 32'd0);
    tick();

    // randomized instruction stream with hazards, flushes, stalls and resets
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      ins        = $urandom;
      ins[6:0]   = opc_pool[$urandom_range(0, 11)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      fetch(ins, $urandom & 32'hFFFF_FFFC);
      rst_n             = ($urandom_range(0, 99) != 0);
      bus.stall_c_i     = ($urandom_range(0, 9) == 0);
      bus.flush_c_i     = ($urandom_range(0, 19) == 0);
      bus.wb_wen_i      = ($urandom_range(0, 1) == 1);
      bus.wb_rd_i       = 5'($urandom_range(0, 7));
      bus.wb_data_i     = $urandom;
      bus.ex_mem_read_i = ($urandom_range(0, 2) == 0);
      bus.ex_rd_i       = 5'($urandom_range(0, 7));
      sample("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
